// File: rtl/alu_defs.sv
// Operation codes and execute-stage state encodings shared by the ALU and the HI/LO unit.
package alu_defs;

  localparam logic [4:0] CARD_MULT  = 5'b10010;
  localparam logic [4:0] CARD_MULTU = 5'b10011;
  localparam logic [4:0] CARD_DIV   = 5'b10100;
  localparam logic [4:0] CARD_DIVU  = 5'b10101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } hilo_state_t;

  function automatic logic is_div_card(input logic [4:0] card);
    return (card == CARD_DIV) || (card == CARD_DIVU);
  endfunction

  function automatic logic is_mul_card(input logic [4:0] card);
    return (card == CARD_MULT) || (card == CARD_MULTU);
  endfunction

  // Two's-complement magnitude when the operand is treated as signed; raw value otherwise.
  // 0x80000000 maps to itself, which the unsigned divider then handles correctly.
  function automatic logic [31:0] abs_if(input logic [31:0] value, input logic is_signed);
    return (is_signed && value[31]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/hilo_unit_if.sv
// EX-stage connection between the pipeline and the HI/LO unit.
interface hilo_unit_if;
  logic        op_valid;
  logic [4:0]  card;
  logic        mthi;
  logic        mtlo;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_lo;
  logic [31:0] alu_hi;
  logic        flush;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, card, mthi, mtlo, src_a, src_b, alu_lo, alu_hi, flush,
    input  stall, hi, lo
  );

  modport slave (
    input  op_valid, card, mthi, mtlo, src_a, src_b, alu_lo, alu_hi, flush,
    output stall, hi, lo
  );
endinterface

// File: rtl/div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB first.
module div_core #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  localparam int CNT_W = $clog2(DIV_ITERS + 1);

  logic             busy;
  logic [CNT_W-1:0] count;
  logic [31:0]      rem_q;
  logic [31:0]      quo_q;
  logic [31:0]      div_q;
  logic [32:0]      trial_shift;
  logic [32:0]      trial_diff;

  // Trial subtraction on the 33-bit shifted partial remainder; bit 32 of the difference is the borrow.
  // The kept remainder always stays below the divisor, so 32 stored bits suffice.
  always_comb begin
    trial_shift = {rem_q, quo_q[31]};
    trial_diff  = trial_shift - {1'b0, div_q};
    done        = busy && (count == CNT_W'(DIV_ITERS - 1));
  end

  // Load on start, then shift the dividend out of the quotient register as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      count <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else if (abort) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= '0;
      rem_q <= '0;
      quo_q <= dividend;
      div_q <= divisor;
    end else if (busy) begin
      if (!trial_diff[32]) begin
        rem_q <= trial_diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= trial_shift[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
      count <= count + CNT_W'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO owner: captures multiply products, runs divisions, services MTHI/MTLO and stalls EX while dividing.
module hilo_unit
  import alu_defs::*;
#(
  parameter int DIV_ITERS = 32
) (
  input logic       clk,
  input logic       rst,
  hilo_unit_if.slave bus
);

  hilo_state_t state;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        q_neg;
  logic        r_neg;
  logic        div_zero;
  logic [31:0] dividend_raw;

  logic        signed_div;
  logic        accept_div;
  logic        core_abort;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] core_quo;
  logic [31:0] core_rem;
  logic        core_done;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;

  // Division acceptance, operand magnitudes and the sign-corrected results for the DONE write.
  always_comb begin
    signed_div = (bus.card == CARD_DIV);
    accept_div = (state == IDLE) && bus.op_valid && is_div_card(bus.card) && !bus.flush;
    core_abort = bus.flush && (state != IDLE);
    a_mag      = abs_if(bus.src_a, signed_div);
    b_mag      = abs_if(bus.src_b, signed_div);
    quo_fixed  = q_neg ? (~core_quo + 32'd1) : core_quo;
    rem_fixed  = r_neg ? (~core_rem + 32'd1) : core_rem;
  end

  div_core #(
    .DIV_ITERS(DIV_ITERS)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_div),
    .abort     (core_abort),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (core_quo),
    .remainder (core_rem),
    .done      (core_done)
  );

  // Control FSM and architectural HI/LO; flush suppresses every write and abandons any division.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      div_zero     <= 1'b0;
      dividend_raw <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid && !bus.flush) begin
            if (is_mul_card(bus.card)) begin
              hi_q <= bus.alu_hi;
              lo_q <= bus.alu_lo;
            end else if (is_div_card(bus.card)) begin
              q_neg        <= signed_div && (bus.src_a[31] ^ bus.src_b[31]);
              r_neg        <= signed_div && bus.src_a[31];
              div_zero     <= (bus.src_b == 32'd0);
              dividend_raw <= bus.src_a;
              state        <= CALC;
            end else begin
              if (bus.mthi) hi_q <= bus.src_a;
              if (bus.mtlo) lo_q <= bus.src_a;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
          end else if (core_done) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!bus.flush) begin
            if (div_zero) begin
              hi_q <= dividend_raw;
              lo_q <= 32'hFFFF_FFFF;
            end else begin
              hi_q <= rem_fixed;
              lo_q <= quo_fixed;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall = accept_div || ((state == CALC) && !bus.flush);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Execute-stage HI/LO owner, directly downstream of the ALU. Captures the 64-bit MULT/MULTU product the ALU emits on `F`/`AddF`. Runs DIV/DIVU iteratively, since the ALU has no divider. Services MTHI/MTLO writes and holds the architectural HI and LO registers read by MFHI/MFLO. Asserts `stall` to freeze the pipeline while a division is in flight.

## Interface
Parameters:
- `DIV_ITERS`, 32: restoring-division iterations, one per quotient bit; fixed at operand width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op_valid` in 1: EX holds a live instruction for this unit.
- `card` in 5: ALU operation code; this unit acts on MULT 5'b10010, MULTU 5'b10011, DIV 5'b10100, DIVU 5'b10101.
- `mthi` in 1: EX instruction is MTHI; ignored unless `op_valid`.
- `mtlo` in 1: EX instruction is MTLO; ignored unless `op_valid`.
- `src_a` in 32: rs value; dividend for DIV/DIVU, write data for MTHI/MTLO.
- `src_b` in 32: rt value; divisor.
- `alu_lo` in 32: ALU `F`, the low product word.
- `alu_hi` in 32: ALU `AddF`, the high product word.
- `flush` in 1: cancel the EX instruction (exception or redirect).
- `stall` out 1: hold IF–EX; 0 at reset.
- `hi` out 32: registered HI; 0 at reset.
- `lo` out 32: registered LO; 0 at reset.

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE, `hi`=`lo`=0, `stall`=0, iteration count 0.
- IDLE, `op_valid`, `!flush`:
  - MULT/MULTU: `hi`←`alu_hi`, `lo`←`alu_lo` at the clock edge. No stall.
  - MTHI: `hi`←`src_a`. MTLO: `lo`←`src_a`. Neither touches the other register.
  - DIV/DIVU: latch operands and enter CALC.
    - DIV takes magnitudes and records the quotient sign (`a[31]^b[31]`) and the remainder sign (`a[31]`).
    - DIVU takes the raw operands.
- CALC: one restoring step per cycle on a 33-bit partial remainder. After `DIV_ITERS` steps, go to DONE.
- DONE:
  - Apply sign fixup: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - `lo`←quotient, `hi`←remainder at the clock edge, then return to IDLE.
  - The EX instruction is still presented in this cycle and must not restart a division.
- Divisor zero: no exception, full latency. `hi`←dividend (original `src_a`), `lo`←32'hFFFFFFFF, for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`←0x80000000, `hi`←0, with no trap.
- `flush` in any state:
  - No HI/LO write occurs that cycle.
  - CALC or DONE aborts to IDLE; latched operands are discarded.
- `rst` mid-division: immediate IDLE and all outputs return to their reset values at that edge.

## Timing
- `stall` is combinational: `(IDLE & op_valid & card∈{DIV,DIVU} & !flush) | (CALC & !flush)`.
- Division accepted in cycle 0:
  - CALC occupies cycles 1–32 and DONE is cycle 33.
  - `stall` is high in cycles 0–32 (33 cycles) and low in cycle 33.
  - New `hi`/`lo` values are visible from cycle 34.
- MULT/MTHI/MTLO in cycle N: new value visible on `hi`/`lo` in cycle N+1. An MFHI/MFLO in EX at N+1 reads it with no bypass.
- Only one HI/LO writer is active per cycle; an EX instruction is exactly one of these kinds.
- `card` and operands are sampled only in IDLE. Their values during CALC and DONE are don't-care.

## Structure
- Shared package `alu_defs`:
  - The 5-bit operation codes, currently local defines of the ALU; both blocks import from it.
  - The state enum IDLE/CALC/DONE.
- Sub-module `div_core` holds the iterative restoring datapath: partial remainder, quotient shift register, counter, and `start`/`abort`/`done` control.
- `hilo_unit` keeps the FSM, sign handling, divide-by-zero override and the HI/LO registers.

## Test plan
- MULT, `alu_hi`=0xFFFFFFFF, `alu_lo`=0xFFFFFFFE -> next cycle `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE; `stall` never rises.
- DIVU 100 / 7 -> `stall` high for exactly 33 cycles; from cycle 34, `lo`=14, `hi`=2.
- DIV -7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV 0x80000000 / -1 -> `lo`=0x80000000, `hi`=0.
- DIVU 0x1234 / 0 -> `hi`=0x1234, `lo`=0xFFFFFFFF, full latency.
- DIVU with `flush` pulsed in CALC cycle 10 -> `stall` drops the same cycle and `hi`/`lo` are unchanged. A following MTLO 0x55 then writes `lo`=0x55 next cycle. `rst` raised mid-CALC forces `hi`=`lo`=0, `stall`=0.
